// File: rtl/uart_rx_param_if.sv
// Output bus of the UART receiver: received word, its error flags and the
// overrun pulse, plus the consumer's ready.
//
// Handshake: the receiver raises rx_valid with rx_data/frame_err/parity_err
// and holds all three stable until a cycle where rx_valid & rx_ready are both
// high; the word is taken on that edge and rx_valid falls. rx_ready has no
// meaning while rx_valid is low. overrun is a standalone one-cycle pulse and
// is not qualified by rx_valid.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, mid-bit sampling,
// configurable data/parity/stop format, false-start rejection and a
// valid/ready output with framing, parity and overrun reporting.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rxd,
    uart_rx_param_if.master bus,
    output logic            busy,
    output logic [2:0]      state_dbg
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 sync1;
    logic                 rxs;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 perr;
    logic                 ferr;
    logic                 cnt_last;
    logic                 data_smp;
    logic                 par_smp;
    logic                 stop_smp;
    logic                 commit;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 parity_err_q;
    logic                 overrun_q;

    assign cnt_last = (cnt == CNT_LAST);

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; every decision is taken on the synchronised line.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (!rxs) next_state = S_START;
            end
            S_START: begin
                // A line that is high again at mid start bit was a glitch.
                if (cnt == CNT_HALF) next_state = rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (cnt_last && bit_idx == LAST_DATA)
                    next_state = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (cnt_last) next_state = S_STOP;
            end
            S_STOP: begin
                // A bad stop bit may be a break; wait for the line to recover.
                if (cnt_last && bit_idx == LAST_STOP)
                    next_state = (ferr || !rxs) ? S_BREAK : S_IDLE;
            end
            S_BREAK: begin
                if (rxs) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs and sample strobes.
    always_comb begin
        busy      = (state != S_IDLE);
        state_dbg = state;
        data_smp  = (state == S_DATA)   && cnt_last;
        par_smp   = (state == S_PARITY) && cnt_last;
        stop_smp  = (state == S_STOP)   && cnt_last;
        commit    = stop_smp && (bit_idx == LAST_STOP);
    end

    // Bit-period counter and bit index; both restart on every state entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else if (next_state != state) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else if (state == S_IDLE || state == S_BREAK) begin
            cnt <= '0;
        end else if (cnt_last) begin
            cnt <= '0;
            if (data_smp || stop_smp) bit_idx <= bit_idx + 4'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame datapath: LSB-first shift register plus parity/framing flags,
    // cleared while idle so each frame starts clean.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                perr <= 1'b0;
                ferr <= 1'b0;
            end
            if (data_smp) shift <= {rxs, shift[DATA_BITS-1:1]};
            if (par_smp) begin
                if (PARITY_MODE == 1) perr <= ~(^shift ^ rxs);
                else                  perr <=  (^shift ^ rxs);
            end
            if (stop_smp && !rxs) ferr <= 1'b1;
        end
    end

    // Output register: present a new word at commit unless the previous one
    // is still waiting, in which case drop the new one and flag overrun.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;
            if (commit) begin
                if (!rx_valid_q || bus.rx_ready) begin
                    rx_data_q    <= shift;
                    frame_err_q  <= ferr | ~rxs;
                    parity_err_q <= perr;
                    rx_valid_q   <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 and an 8E1 instance at 16 clocks per bit,
// a vector table of frames with hand-computed results, and directed
// sequences for glitch, break, overrun and mid-frame reset.
module tb_uart_rx_param;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd_n = 1'b1;
    logic       rxd_e = 1'b1;
    logic       ready_n = 1'b1;
    logic       busy_n, busy_e;
    logic [2:0] dbg_n, dbg_e;

    uart_rx_param_if #(.DATA_BITS(8)) bus_n ();
    uart_rx_param_if #(.DATA_BITS(8)) bus_e ();

    assign bus_n.rx_ready = ready_n;
    assign bus_e.rx_ready = 1'b1;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_n (
        .clk(clk), .rst(rst), .rxd(rxd_n), .bus(bus_n), .busy(busy_n), .state_dbg(dbg_n)
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) dut_e (
        .clk(clk), .rst(rst), .rxd(rxd_e), .bus(bus_e), .busy(busy_e), .state_dbg(dbg_e)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    // Word format: {frame_err, parity_err, rx_data}
    logic [9:0] exp_q[$];
    logic [9:0] got_n[$];
    logic [9:0] got_e[$];
    int rise_n = 0, rise_e = 0, rises_n = 0, rises_e = 0, ovr_n = 0, ovr_e = 0;
    logic prev_v_n = 1'b0, prev_v_e = 1'b0;

    // Monitor: samples mid-cycle, after the bench has driven its inputs.
    always @(posedge clk) begin
        #2;
        if (bus_n.rx_valid && bus_n.rx_ready)
            got_n.push_back({bus_n.frame_err, bus_n.parity_err, bus_n.rx_data});
        if (bus_e.rx_valid && bus_e.rx_ready)
            got_e.push_back({bus_e.frame_err, bus_e.parity_err, bus_e.rx_data});
        if (bus_n.overrun) ovr_n++;
        if (bus_e.overrun) ovr_e++;
        if (bus_n.rx_valid && !prev_v_n) begin rise_n = cyc; rises_n++; end
        if (bus_e.rx_valid && !prev_v_e) begin rise_e = cyc; rises_e++; end
        prev_v_n = bus_n.rx_valid;
        prev_v_e = bus_e.rx_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input bit sel, input logic b);
        if (sel) rxd_e = b;
        else     rxd_n = b;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] data, input bit use_par,
                              input bit par_bit, input bit stop_bit, input bit idle_after);
        drive_line(sel, 1'b0);
        fall_cyc = cyc;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            drive_line(sel, data[i]);
            repeat (CPB) tick();
        end
        if (use_par) begin
            drive_line(sel, par_bit);
            repeat (CPB) tick();
        end
        drive_line(sel, stop_bit);
        repeat (CPB) tick();
        if (idle_after) drive_line(sel, 1'b1);
    endtask

    // Bounded wait for one accepted word from the selected instance.
    task automatic get_word(input bit sel, output logic [9:0] w, output bit ok);
        ok = 1'b0;
        w  = '0;
        for (int k = 0; k < 40; k++) begin
            if (sel ? (got_e.size() > 0) : (got_n.size() > 0)) begin
                w  = sel ? got_e.pop_front() : got_n.pop_front();
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         sel;       // 0 = 8N1 instance, 1 = 8E1 instance
        logic [7:0] data;
        bit         use_par;
        bit         par_bit;
        bit         stop_bit;
        logic [9:0] exp_word;
        int         exp_lat;   // pin fall to rx_valid rise, in cycles
    } vec_t;

    vec_t vecs[10];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [9:0] w;
        bit         ok;
        int         cnt_busy;
        int         r0, o0;

        // 8N1 latency = 2 + 8 + 9*16 + 1 = 155; 8E1 = 2 + 8 + 10*16 + 1 = 171
        vecs[0] = '{0, 8'h72, 0, 0, 1, 10'h072, 155};
        vecs[1] = '{0, 8'h00, 0, 0, 1, 10'h000, 155};
        vecs[2] = '{0, 8'hFF, 0, 0, 1, 10'h0FF, 155};
        vecs[3] = '{0, 8'hA5, 0, 0, 1, 10'h0A5, 155};
        vecs[4] = '{1, 8'h67, 1, 1, 1, 10'h067, 171}; // five ones, even parity bit 1
        vecs[5] = '{1, 8'h67, 1, 0, 1, 10'h167, 171}; // wrong parity
        vecs[6] = '{1, 8'h00, 1, 0, 1, 10'h000, 171};
        vecs[7] = '{1, 8'h81, 1, 1, 1, 10'h181, 171}; // two ones, parity 1 wrong
        vecs[8] = '{0, 8'h3C, 0, 0, 0, 10'h23C, 155}; // stop bit 0
        vecs[9] = '{1, 8'h55, 1, 0, 0, 10'h255, 171}; // good parity, bad stop

        // Reset
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("reset rx_valid_n", bus_n.rx_valid, 0);
        check("reset rx_data_n", bus_n.rx_data, 0);
        check("reset flags_n", {bus_n.frame_err, bus_n.parity_err, bus_n.overrun}, 0);
        check("reset busy_n", busy_n, 0);
        check("reset rx_valid_e", bus_e.rx_valid, 0);
        check("reset busy_e", busy_e, 0);
        repeat (5) tick();

        // Table-driven frames
        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].exp_word);
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].use_par, vecs[i].par_bit,
                       vecs[i].stop_bit, 1'b1);
            get_word(vecs[i].sel, w, ok);
            check($sformatf("vec%0d arrived", i), ok, 1);
            check($sformatf("vec%0d word", i), w, exp_q.pop_front());
            check($sformatf("vec%0d latency", i),
                  (vecs[i].sel ? rise_e : rise_n) - fall_cyc, vecs[i].exp_lat);
            check($sformatf("vec%0d valid dropped", i),
                  vecs[i].sel ? bus_e.rx_valid : bus_n.rx_valid, 0);
            repeat (20) tick();
        end

        // Glitch: 4-cycle low pulse is rejected at mid start bit
        r0 = rises_n;
        cnt_busy = 0;
        rxd_n = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 4) rxd_n = 1'b1;
            if (busy_n) cnt_busy++;
        end
        check("glitch busy cycles", cnt_busy, 8);
        check("glitch no word", rises_n - r0, 0);
        check("glitch state idle", dbg_n, 3'd0);

        // Break: bad stop bit then line held low for 40 bit periods
        r0 = rises_n;
        send_frame(0, 8'h00, 0, 0, 0, 0);
        repeat (40 * CPB) tick();
        check("break one word", rises_n - r0, 1);
        get_word(0, w, ok);
        check("break word", w, 10'h200);
        check("break state", dbg_n, 3'd5);
        rxd_n = 1'b1;
        repeat (5) tick();
        check("break recovered", dbg_n, 3'd0);
        repeat (10) tick();
        send_frame(0, 8'h62, 0, 0, 1, 1);
        get_word(0, w, ok);
        check("after break word", w, 10'h062);
        repeat (20) tick();

        // Overrun: consumer stalled, two frames back-to-back
        ready_n = 1'b0;
        o0 = ovr_n;
        send_frame(0, 8'h72, 0, 0, 1, 1);
        send_frame(0, 8'h67, 0, 0, 1, 1);
        check("ovr held valid", bus_n.rx_valid, 1);
        check("ovr held data", bus_n.rx_data, 8'h72);
        check("ovr pulses", ovr_n - o0, 1);
        ready_n = 1'b1;
        tick();
        tick();
        check("ovr valid fell", bus_n.rx_valid, 0);
        get_word(0, w, ok);
        check("ovr accepted word", w, 10'h072);
        repeat (40) tick();
        check("ovr second dropped", got_n.size(), 0);

        // Reset in the middle of the data bits of 0x62
        rxd_n = 1'b0;
        repeat (CPB) tick();
        rxd_n = 1'b0;              // bit0 of 0x62
        repeat (CPB) tick();
        rxd_n = 1'b1;              // bit1 of 0x62
        repeat (CPB / 2) tick();
        check("pre-reset busy", busy_n, 1);
        rst = 1'b0;
        tick();
        check("midreset rx_data", bus_n.rx_data, 0);
        check("midreset valid/flags", {bus_n.rx_valid, bus_n.frame_err, bus_n.parity_err,
                                       bus_n.overrun}, 0);
        check("midreset busy", busy_n, 0);
        rst = 1'b1;
        repeat (20) tick();
        r0 = rises_n;
        send_frame(0, 8'h67, 0, 0, 1, 1);
        get_word(0, w, ok);
        check("post-reset word", w, 10'h067);
        repeat (40) tick();
        check("post-reset single word", rises_n - r0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds the following over the fixed block:
- 2-FF input synchroniser and mid-bit sampling.
- Configurable data width, parity and stop bits.
- False-start rejection.
- Valid/ready output handshake with framing, parity and overrun reporting.

It sits between the board RX pin and downstream command decoders, such as the LED colour decoder.

Parameters:
CLKS_PER_BIT, 1085, clock cycles per bit period (125 MHz / 115200); legal range 4..65535
DATA_BITS, 8, data bits per frame, LSB first; legal range 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits checked; 1 or 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-low
rxd  input  1  asynchronous serial input; idle high
rx_data  output  DATA_BITS  received word; valid while rx_valid=1
rx_valid  output  1  word available; held until accepted
rx_ready  input  1  consumer accepts word when rx_valid & rx_ready
frame_err  output  1  stop bit sampled 0 for the presented word; qualified by rx_valid
parity_err  output  1  parity mismatch for the presented word; qualified by rx_valid; always 0 when PARITY_MODE=0
overrun  output  1  one-cycle pulse: a frame completed while rx_valid=1 and no accept occurred that cycle
busy  output  1  1 whenever the FSM is not in IDLE

Behaviour:
Reset (rst=0 at a clk edge):
- Synchroniser flops go to 1; FSM goes to IDLE; bit counter and clock counter go to 0.
- rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
- Reset mid-frame abandons the frame with no output.

Input synchronisation:
- rxd passes through two flops; rxs is the second flop's output.
- All FSM decisions use rxs, so detection lags the pin by 2 cycles.

Clock counter: width = clog2(CLKS_PER_BIT). It clears on every state entry.

States:
- IDLE: on rxs=0, go to START.
- START: when the counter reaches (CLKS_PER_BIT/2)-1 (mid start bit):
  - rxs=0: go to DATA, clear the counter.
  - rxs=1: false start; return to IDLE with no output.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rxs into shift[bit_idx], LSB first.
  - After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY: after CLKS_PER_BIT cycles, sample rxs.
  - Odd: XOR of data bits and parity bit must be 1.
  - Even: that XOR must be 0.
  - A mismatch sets the internal perr.
- STOP: sample every CLKS_PER_BIT cycles, STOP_BITS times.
  - Any 0 sample sets the internal ferr.
  - After the final sample, commit (see below) and then:
    - ferr=0: go to IDLE.
    - ferr=1: go to BREAK_WAIT.
- BREAK_WAIT: stay until rxs=1, then go to IDLE. This stops a line break from retriggering START.

Commit (cycle of the last stop sample), registered so outputs change on the next edge:
- If rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: load rx_data, frame_err and parity_err, and set rx_valid=1.
- Otherwise: the presented word and its flags are kept, the new word is dropped, and overrun pulses for 1 cycle.

Handshake:
- rx_valid falls on the edge after a cycle with rx_valid & rx_ready.
- rx_data and the error flags are stable while rx_valid=1.
- rx_ready is ignored while rx_valid=0.

Latency: rx_valid rises 1 cycle after the final stop-bit sample. That is 2 + CLKS_PER_BIT/2 + (DATA_BITS + P + STOP_BITS)×CLKS_PER_BIT + 1 cycles after the pin falls, where P=1 if parity is enabled, else 0.

Back-to-back frames: a start edge seen in IDLE immediately after the stop sample is accepted, which tolerates up to half a bit of transmitter skew.

Test Plan:
- CLKS_PER_BIT=16, 8N1; send 0x72 with rx_ready=1 -> rx_valid pulses for 1 cycle with rx_data=0x72, frame_err=0, parity_err=0; rx_valid rises 2+8+9×16+1=155 cycles after the falling edge.
- Low glitch of 4 cycles on rxd -> START aborts at the mid-bit sample, FSM returns to IDLE, no rx_valid; busy is high for ~8 cycles only.
- PARITY_MODE=2; send 0x67 with parity bit 1 (correct) -> parity_err=0; then send 0x67 with parity bit 0 -> rx_valid with parity_err=1 and rx_data=0x67.
- Stop bit driven 0, then line held low for 40 bit periods -> one word with frame_err=1; FSM stays in BREAK_WAIT with no further words until rxd rises; then send 0x62 -> clean word.
- rx_ready=0; send 0x72 then 0x67 back-to-back -> rx_data stays 0x72 and overrun pulses once at the second stop sample; raise rx_ready -> 0x72 accepted, rx_valid falls; no 0x67 is delivered.
- Reset asserted mid-DATA of frame 0x62 -> all outputs 0 on the next edge; the next full frame 0x67 is received correctly.
